// File: rtl/window_linebuffer_pkg.sv
// Shared defaults and helpers for the sliding-window line buffer.
// Window elements are indexed row-major, with row 0 being the oldest line.
package window_pkg;
  localparam int DEF_PIX_W = 7;
  localparam int DEF_K     = 9;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  localparam int WIN_BITS = DEF_K * DEF_K * DEF_PIX_W;
  localparam int ROW_W    = $clog2(DEF_IMG_H);
  localparam int COL_W    = $clog2(DEF_IMG_W);

  function automatic int win_idx(input int r, input int c, input int k = DEF_K);
    return r * k + c;
  endfunction
endpackage

// File: rtl/window_linebuffer_line_fifo.sv
// Fixed-depth shift delay of one image line.
// The tap is the pixel from exactly one line earlier.
module line_fifo
  import window_pkg::*;
#(
  parameter int W     = DEF_PIX_W,
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] tap
);
  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately unreset; validity logic upstream hides stale contents.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign tap = mem[DEPTH-1];
endmodule

// File: rtl/window_linebuffer.sv
// Raster pixel stream to KxK sliding window producer.
// Holds K-1 image lines plus the window register; flags each complete in-image window.
module window_linebuffer
  import window_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int K     = DEF_K,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_W-1:0]           pix_in,
  input  logic                       pix_valid,
  input  logic                       frame_start,
  output logic [K*K*PIX_W-1:0]       win_out,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0]    row_cnt, row_eff;
  logic [CW-1:0]    col_cnt, col_eff;
  logic             win_full, last_pix;
  logic [PIX_W-1:0] fifo_in [K-1];
  logic [PIX_W-1:0] taps    [K-1];
  logic [PIX_W-1:0] win_q   [K][K];

  // frame_start overrides the counters so the marked pixel lands at (0,0)
  assign row_eff  = frame_start ? '0 : row_cnt;
  assign col_eff  = frame_start ? '0 : col_cnt;
  assign win_full = (row_eff >= RW'(K-1)) && (col_eff >= CW'(K-1));
  assign last_pix = (row_eff == RW'(IMG_H-1)) && (col_eff == CW'(IMG_W-1));

  assign fifo_in[0] = pix_in;
  for (genvar g = 0; g < K-1; g++) begin : g_line
    if (g > 0) begin : g_link
      assign fifo_in[g] = taps[g-1];
    end
    line_fifo #(.W(PIX_W), .DEPTH(IMG_W)) u_line (
      .clk (clk),
      .en  (pix_valid),
      .din (fifo_in[g]),
      .tap (taps[g])
    );
  end

  always_comb begin
    win_out = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_out[win_idx(r, c, K)*PIX_W +: PIX_W] = win_q[r][c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else begin
      win_valid  <= pix_valid && win_full;
      frame_done <= pix_valid && last_pix;
      if (pix_valid) begin
        if (col_eff == CW'(IMG_W-1)) begin
          col_cnt <= '0;
          row_cnt <= (row_eff == RW'(IMG_H-1)) ? '0 : row_eff + 1'b1;
        end else begin
          col_cnt <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
        if (win_full) begin
          win_row <= row_eff - RW'(K-1);
          win_col <= col_eff - CW'(K-1);
        end
        // Shift left; new right column is taps oldest-on-top plus the live pixel.
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K-1; c++) win_q[r][c] <= win_q[r][c+1];
        for (int r = 0; r < K-1; r++) win_q[r][K-1] <= taps[K-2-r];
        win_q[K-1][K-1] <= pix_in;
      end
    end
  end
endmodule
